// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: RISC-V instruction width and the canonical NOP
// shown to decode whenever the head is empty.
package fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue; master is the fetch+decode side,
// slave is the queue itself.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH_PC  = 32,
  parameter int WIDTH_PTR = 3
);

  logic [INSTR_W-1:0]   i_instr;
  logic [WIDTH_PC-1:0]  i_pc;
  logic                 i_valid;
  logic                 o_ready;
  logic [INSTR_W-1:0]   o_instr;
  logic [WIDTH_PC-1:0]  o_pc;
  logic                 o_imask;
  logic                 i_en;
  logic                 i_kill;
  logic [WIDTH_PTR:0]   o_count;

  modport master (
    output i_instr, i_pc, i_valid, i_en, i_kill,
    input  o_ready, o_instr, o_pc, o_imask, o_count
  );

  modport slave (
    input  i_instr, i_pc, i_valid, i_en, i_kill,
    output o_ready, o_instr, o_pc, o_imask, o_count
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// Instruction/PC storage: DEPTH-entry register array, no reset.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none here, the caller gates the write enable.
module fetch_queue_mem #(
  parameter int DAT_W     = 64,
  parameter int DEPTH     = 8,
  parameter int WIDTH_PTR = 3
) (
  input  logic                 clk,
  input  logic                 wr_vld,
  input  logic [WIDTH_PTR-1:0] wr_addr,
  input  logic [DAT_W-1:0]     wr_dat,
  input  logic [WIDTH_PTR-1:0] rd_addr,
  output logic [DAT_W-1:0]     rd_dat
);

  logic [DAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode; i_kill flushes it in one cycle.
// Latency: 1 cycle push-to-head; 0 cycles when empty if FETCHQ_BYPASS_EN is defined.
// Backpressure: o_ready drops when full (registered count only); fetch holds its data.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH_PC  = 32,
  parameter int DEPTH     = 8,
  parameter int WIDTH_PTR = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  fq
);

  localparam int ENT_W = INSTR_W + WIDTH_PC;
  localparam logic [WIDTH_PTR:0] CNT_FULL = (WIDTH_PTR+1)'(DEPTH);

  logic [WIDTH_PTR-1:0] rd_ptr;
  logic [WIDTH_PTR-1:0] wr_ptr;
  logic [WIDTH_PTR:0]   count;
  logic [ENT_W-1:0]     head_dat;
  logic                 empty;
  logic                 full;
  logic                 byp;
  logic                 push_en;
  logic                 pop_en;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

`ifdef FETCHQ_BYPASS_EN
  assign byp = empty & fq.i_valid & ~fq.i_kill;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word that decode takes immediately never touches the array.
  assign push_en = fq.i_valid & ~full & ~fq.i_kill & ~(byp & fq.i_en);
  assign pop_en  = ~empty & fq.i_en;

  assign fq.o_ready = ~full;
  assign fq.o_imask = ~empty | byp;
  assign fq.o_count = count;

  always_comb begin
    fq.o_instr = INSTR_NOP;
    fq.o_pc    = '0;
    if (byp) begin
      fq.o_instr = fq.i_instr;
      fq.o_pc    = fq.i_pc;
    end else if (!empty) begin
      fq.o_instr = head_dat[ENT_W-1 -: INSTR_W];
      fq.o_pc    = head_dat[WIDTH_PC-1:0];
    end
  end

  fetch_queue_mem #(
    .DAT_W     (ENT_W),
    .DEPTH     (DEPTH),
    .WIDTH_PTR (WIDTH_PTR)
  ) u_mem (
    .clk     (clk),
    .wr_vld  (push_en),
    .wr_addr (wr_ptr),
    .wr_dat  ({fq.i_instr, fq.i_pc}),
    .rd_addr (rd_ptr),
    .rd_dat  (head_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (fq.i_kill) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ordering, full/wrap, push+pop, kill, bypass, async reset.
// Expected values are hand-computed constants.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int WPC  = 32;
  localparam int DEP  = 8;
  localparam int WPTR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  fetch_queue_if #(.WIDTH_PC(WPC), .WIDTH_PTR(WPTR)) fq ();

  fetch_queue #(.WIDTH_PC(WPC), .DEPTH(DEP), .WIDTH_PTR(WPTR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] ins, input logic [31:0] pc,
                       input logic en, input logic kill);
    fq.i_valid = vld;
    fq.i_instr = ins;
    fq.i_pc    = pc;
    fq.i_en    = en;
    fq.i_kill  = kill;
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    drive(1'b1, ins, pc, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Check the head, then pop it.
  task automatic pop_chk(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk({tag, "_imask"}, 64'(fq.o_imask), 64'd1);
    chk({tag, "_instr"}, 64'(fq.o_instr), 64'(ins));
    chk({tag, "_pc"},    64'(fq.o_pc),    64'(pc));
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // 1. reset and idle
    #10;
    chk("rst_imask", 64'(fq.o_imask), 64'd0);
    chk("rst_ready", 64'(fq.o_ready), 64'd1);
    chk("rst_count", 64'(fq.o_count), 64'd0);
    chk("rst_instr", 64'(fq.o_instr), 64'h13);
    chk("rst_pc",    64'(fq.o_pc),    64'd0);
    #3 rst_n = 1'b1;
    tick();
    tick();
    chk("idle_imask", 64'(fq.o_imask), 64'd0);
    chk("idle_count", 64'(fq.o_count), 64'd0);

    // 2. ordered pass-through
    push(32'h0000_2137, 32'h0);
    push(32'h0440_00ef, 32'h4);
    push(32'hfe01_0113, 32'h8);
    chk("t2_count3", 64'(fq.o_count), 64'd3);
    pop_chk("t2_h0", 32'h0000_2137, 32'h0);
    pop_chk("t2_h1", 32'h0440_00ef, 32'h4);
    pop_chk("t2_h2", 32'hfe01_0113, 32'h8);
    chk("t2_empty_imask", 64'(fq.o_imask), 64'd0);
    chk("t2_empty_instr", 64'(fq.o_instr), 64'h13);
    // Pop while empty must not underflow.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("t2_underflow_count", 64'(fq.o_count), 64'd0);
    chk("t2_underflow_ready", 64'(fq.o_ready), 64'd1);

    // 3. full and wrap
    for (int k = 0; k < 8; k++) push(32'h1000_0000 + 32'(k), 32'(k * 4));
    chk("t3_full_count", 64'(fq.o_count), 64'd8);
    chk("t3_full_ready", 64'(fq.o_ready), 64'd0);
    drive(1'b1, 32'h1000_0008, 32'd32, 1'b0, 1'b0);
    tick();
    chk("t3_refuse_count", 64'(fq.o_count), 64'd8);
    // Full refuses the push even with a concurrent pop.
    drive(1'b1, 32'h1000_0008, 32'd32, 1'b1, 1'b0);
    chk("t3_pp_head", 64'(fq.o_instr), 64'h1000_0000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t3_pp_count", 64'(fq.o_count), 64'd7);
    pop_chk("t3_pop1", 32'h1000_0001, 32'd4);
    pop_chk("t3_pop2", 32'h1000_0002, 32'd8);
    for (int k = 8; k < 11; k++) push(32'h1000_0000 + 32'(k), 32'(k * 4));
    chk("t3_refill_count", 64'(fq.o_count), 64'd8);
    for (int k = 3; k < 11; k++) pop_chk($sformatf("t3_drain%0d", k), 32'h1000_0000 + 32'(k), 32'(k * 4));
    chk("t3_drained", 64'(fq.o_count), 64'd0);

    // 4. simultaneous push and pop at count 4
    for (int k = 0; k < 4; k++) push(32'h2000_0000 + 32'(k), 32'h100 + 32'(k * 4));
    drive(1'b1, 32'h0081_2e23, 32'h200, 1'b1, 1'b0);
    chk("t4_head_before", 64'(fq.o_instr), 64'h2000_0000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t4_count", 64'(fq.o_count), 64'd4);
    pop_chk("t4_h1", 32'h2000_0001, 32'h104);
    pop_chk("t4_h2", 32'h2000_0002, 32'h108);
    pop_chk("t4_h3", 32'h2000_0003, 32'h10c);
    pop_chk("t4_new", 32'h0081_2e23, 32'h200);

    // 5. kill beats push and pop
    for (int k = 0; k < 5; k++) push(32'h3000_0000 + 32'(k), 32'(k));
    chk("t5_count5", 64'(fq.o_count), 64'd5);
    drive(1'b1, 32'hdead_beef, 32'h300, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t5_count", 64'(fq.o_count), 64'd0);
    chk("t5_imask", 64'(fq.o_imask), 64'd0);
    chk("t5_instr", 64'(fq.o_instr), 64'h13);
    push(32'h0000_0055, 32'h400);
    chk("t5_after_count", 64'(fq.o_count), 64'd1);
    pop_chk("t5_after", 32'h0000_0055, 32'h400);

    // 6. bypass (or one-cycle latency without it)
    drive(1'b1, 32'h0440_00ef, 32'h40, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
    chk("t6_byp_imask", 64'(fq.o_imask), 64'd1);
    chk("t6_byp_instr", 64'(fq.o_instr), 64'h0440_00ef);
    chk("t6_byp_pc",    64'(fq.o_pc),    64'h40);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t6_byp_count", 64'(fq.o_count), 64'd0);
    chk("t6_byp_next_imask", 64'(fq.o_imask), 64'd0);
`else
    chk("t6_nobyp_imask", 64'(fq.o_imask), 64'd0);
    chk("t6_nobyp_instr", 64'(fq.o_instr), 64'h13);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t6_nobyp_count", 64'(fq.o_count), 64'd1);
    pop_chk("t6_nobyp_next", 32'h0440_00ef, 32'h40);
`endif

    // 7. asynchronous reset mid-operation
    push(32'h4000_0000, 32'h500);
    push(32'h4000_0001, 32'h504);
    chk("t7_count2", 64'(fq.o_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_count", 64'(fq.o_count), 64'd0);
    chk("t7_rst_imask", 64'(fq.o_imask), 64'd0);
    chk("t7_rst_instr", 64'(fq.o_instr), 64'h13);
    #3 rst_n = 1'b1;
    tick();
    chk("t7_post_ready", 64'(fq.o_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Circular instruction buffer between the fetch unit and the decode stage.
- Decouples fetch from decode stalls: stores up to DEPTH instruction/PC pairs and presents the oldest one to decode as i_instr / i_imask.
- Decode pops the head with its enable (i_en).
- A kill from branch resolution empties the queue in one cycle.

Parameters:
- WIDTH_PC, 32, width of the program counter stored with each instruction.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- WIDTH_PTR, 3, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_instr  input  32  instruction word from fetch.
- i_pc  input  WIDTH_PC  PC of i_instr.
- i_valid  input  1  fetch offers i_instr/i_pc this cycle.
- o_ready  output  1  queue can accept a push this cycle (not full).
- o_instr  output  32  head instruction to decode.
- o_pc  output  WIDTH_PC  head PC to decode.
- o_imask  output  1  head entry valid (drives decode i_imask).
- i_en  input  1  decode accepts the head this cycle.
- i_kill  input  1  flush all entries (mispredict/redirect).
- o_count  output  WIDTH_PTR+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Read pointer, write pointer and count go to 0.
  - o_imask=0, o_ready=1, o_count=0.
  - o_instr=32'h00000013 (canonical NOP), o_pc=0.
  - Storage array is not reset.
- Push: occurs when i_valid && o_ready; writes the entry at the write pointer, which increments modulo DEPTH.
- Pop: occurs when o_imask && i_en; the read pointer increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- o_ready = (count != DEPTH).
  - Combinational from registered count only; never depends on i_en.
  - A full queue refuses a push even when a pop happens in the same cycle.
- o_imask = (count != 0).
- o_instr/o_pc:
  - When o_imask=1, they present the entry at the read pointer.
  - When o_imask=0, they are forced to NOP and 0.
- Latency (without the optional feature): an instruction pushed in cycle N appears at the head no earlier than cycle N+1.
- Ordering: strict FIFO; pointer wrap from DEPTH-1 to 0 is transparent.
- i_kill has priority over push and pop in the same cycle:
  - Next state: pointers 0, count 0.
  - Any concurrent push is discarded.
  - o_imask=0 from the next cycle.
- Pop with i_en=1 while empty: no effect, no underflow.
- Push with i_valid=1 while full: ignored; fetch must hold its data.
- Reset asserted mid-operation discards all contents immediately, asynchronously.

Optional Feature:
- FETCHQ_BYPASS_EN defined: when count==0 and i_valid=1 and i_kill=0:
  - o_imask=1 and o_instr/o_pc = i_instr/i_pc in the same cycle.
  - If i_en=1 as well, the entry is consumed without being written; pointers and count are unchanged.
  - If i_en=0, a normal push occurs.
- FETCHQ_BYPASS_EN undefined: no combinational path from i_* to o_instr/o_pc/o_imask; minimum latency is 1 cycle.

Decomposition:
- Shared include header holds:
  - the NOP encoding constant (32'h00000013);
  - the RISC-V instruction width (32).
- One sub-module, fetch_queue_mem:
  - DEPTH x (32+WIDTH_PC) register array;
  - one synchronous write port;
  - one asynchronous read port.
- Pointer, count, kill and bypass logic stay in fetch_queue.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n low 10 ns, i_valid=0.
   - Required: o_imask=0, o_ready=1, o_count=0, o_instr=32'h00000013.
2. Ordered pass-through:
   - Stimulus: push 32'h00002137 @pc 0x0, then 32'h044000ef @0x4, then 32'hfe010113 @0x8, with i_en=0; then i_en=1 for 3 cycles.
   - Required: o_count reaches 3, then o_instr follows the same order, then o_imask=0.
3. Full and wrap:
   - Stimulus: push 8 entries with i_en=0; a 9th push is offered with i_valid=1.
   - Required: o_ready=0 and o_count=8, with the 9th entry not stored.
   - Then pop 3 and push 3 more; drain shows entries 3..10 in order across the pointer wrap.
4. Simultaneous push/pop:
   - Stimulus: at count=4, push 32'h00812e23 with i_en=1.
   - Required: o_count stays 4, the head advances, and the new entry appears after the existing three.
5. Kill priority:
   - Stimulus: at count=5, assert i_kill with i_valid=1 and i_en=1.
   - Required: next cycle o_count=0, o_imask=0, and the pushed word never appears.
6. Bypass:
   - Stimulus: with FETCHQ_BYPASS_EN defined and the queue empty, push 32'h044000ef with i_en=1.
   - Required: o_imask=1 and o_instr=32'h044000ef in the same cycle; o_count stays 0.
   - Without the macro, the same stimulus gives o_imask=0 that cycle and 1 the next.
